// File: rtl/game_tick_scheduler.sv
// Game sequencer: IDLE/PLAY/PAUSE/OVER FSM, frame-divided game tick, and direction arbitration.
// All outputs registered (1-cycle latency from inputs); no backpressure, pulses are fire-and-forget.
module game_tick_scheduler #(
    parameter int TICK_FRAMES = 8,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       btn_enter,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       pause,
    input  logic       collision,
    output logic [1:0] state,
    output logic       game_tick,
    output logic [1:0] dir,
    output logic       clear_board
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_e;

    localparam logic [1:0]       D_UP    = 2'b00;
    localparam logic [1:0]       D_DOWN  = 2'b01;
    localparam logic [1:0]       D_LEFT  = 2'b10;
    localparam logic [1:0]       D_RIGHT = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_FRAMES - 1);

    state_e           state_q, state_d;
    logic             game_tick_q, game_tick_d;
    logic             clear_board_q, clear_board_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       pending_q, pending_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             enter_q;

    logic             enter_rise;
    logic             btn_any;
    logic [1:0]       btn_win;

    assign enter_rise = btn_enter & ~enter_q;
    assign btn_any    = btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        if (btn_up)        btn_win = D_UP;
        else if (btn_down) btn_win = D_DOWN;
        else if (btn_left) btn_win = D_LEFT;
        else               btn_win = D_RIGHT;
    end

    always_comb begin
        state_d       = state_q;
        game_tick_d   = 1'b0;
        clear_board_d = 1'b0;
        dir_d         = dir_q;
        pending_d     = pending_q;
        frame_cnt_d   = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enter_rise) begin
                    state_d       = S_PLAY;
                    clear_board_d = 1'b1;
                    dir_d         = D_RIGHT;
                    pending_d     = D_RIGHT;
                    frame_cnt_d   = '0;
                end
            end
            S_PLAY: begin
                // Flipping bit 0 of a direction yields its reverse (UP<->DOWN, LEFT<->RIGHT).
                if (btn_any && (btn_win != (dir_q ^ 2'b01))) begin
                    pending_d = btn_win;
                end
                if (frame_start && !collision) begin
                    if (frame_cnt_q == CNT_LAST) begin
                        frame_cnt_d = '0;
                        game_tick_d = 1'b1;
                        dir_d       = pending_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
                if (collision)  state_d = S_OVER;
                else if (pause) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (!pause) state_d = S_PLAY;
            end
            S_OVER: begin
                if (enter_rise) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // enter_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            game_tick_q   <= 1'b0;
            clear_board_q <= 1'b0;
            dir_q         <= D_RIGHT;
            pending_q     <= D_RIGHT;
            frame_cnt_q   <= '0;
            enter_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            game_tick_q   <= game_tick_d;
            clear_board_q <= clear_board_d;
            dir_q         <= dir_d;
            pending_q     <= pending_d;
            frame_cnt_q   <= frame_cnt_d;
            enter_q       <= btn_enter;
        end
    end

    assign state       = state_q;
    assign game_tick   = game_tick_q;
    assign dir         = dir_q;
    assign clear_board = clear_board_q;

endmodule
